operand_loader: RTL
===================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16; the number of consecutive stable cycles required before the debounced button level changes; legal range 2..65535.
REQ-002 Parameter DATA_W, default 8; the operand width.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 btn_load  input  1  raw, bouncy load pushbutton.
REQ-006 btn_clr  input  1  synchronous clear request, already clean, active-high.
REQ-007 sw  input  DATA_W  operand value presented on the switches.
REQ-008 reg_a  output  DATA_W  captured operand A.
REQ-009 reg_b  output  DATA_W  captured operand B.
REQ-010 valid  output  1  high while both operands are captured (state READY).
REQ-011 state_o  output  2  current state encoding, for the display stage.
REQ-012 load_pulse  output  1  one-cycle strobe on the cycle after any operand capture.

Function
REQ-013 The FSM SHALL have states LOAD_A=0, LOAD_B=1 and READY=2; encoding 3 is unused and SHALL recover to LOAD_A on the next edge.
REQ-014 The button path SHALL consist of an optional synchronizer (REQ-027) followed by a debouncer.
REQ-015 The debouncer SHALL hold a debounced level and a counter; while the input equals the debounced level, the counter SHALL clear to 0.
REQ-016 While the input differs from the debounced level, the counter SHALL increment; when it reaches DEBOUNCE_CYCLES-1, the debounced level SHALL toggle on that edge and the counter SHALL clear.
REQ-017 A press event SHALL be a one-cycle pulse on a 0->1 transition of the debounced level; release SHALL generate no event.
REQ-018 On a press in LOAD_A: reg_a <= sw, next state LOAD_B.
REQ-019 On a press in LOAD_B: reg_b <= sw, next state READY, valid=1.
REQ-020 On a press in READY: next state LOAD_A, valid=0; reg_a and reg_b SHALL hold their values.
REQ-021 Captures SHALL occur on the same edge that the press event is sampled; load_pulse SHALL be high for exactly the following cycle.
REQ-022 A btn_clr high on an edge SHALL force LOAD_A, valid=0 and reg_a=reg_b=0; btn_clr SHALL win over a simultaneous press, and that press SHALL be discarded.
REQ-023 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no event; a held button SHALL produce exactly one event.
REQ-024 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap past DEBOUNCE_CYCLES-1.

Reset
REQ-025 While rst is high, the block SHALL immediately hold: state LOAD_A, reg_a=0, reg_b=0, valid=0, load_pulse=0, debounced level 0, counter 0, synchronizer flops 0.
REQ-026 A reset asserted mid-debounce or mid-sequence SHALL abandon the partial press; after rst falls, a held button SHALL be re-debounced from count 0.

Configuration
REQ-027 With LOADER_SYNC_EN defined, btn_load SHALL pass through a 2-flop synchronizer, and the first capture SHALL occur DEBOUNCE_CYCLES+2 edges after btn_load is first sampled high. Without the macro, the raw input SHALL feed the debouncer directly, and the latency SHALL be DEBOUNCE_CYCLES edges.

Structure
REQ-028 The shared package alu_pkg SHALL hold the loader_state_t enum (LOAD_A, LOAD_B, READY) and the constant DEBOUNCE_DEFAULT=16.
REQ-029 The synchronizer and debouncer SHALL be one sub-module, btn_debounce, with ports clk, rst, btn_in and press; the FSM and operand registers SHALL reside in operand_loader.

Verification
REQ-030 Use DEBOUNCE_CYCLES=4 with LOADER_SYNC_EN defined. Apply rst, set sw=0x3C and hold btn_load high for 10 cycles -> reg_a=0x3C on edge 6, state_o=1, load_pulse high for one cycle, valid=0.
REQ-031 Set sw=0xA5 and press for 10 cycles, then release -> reg_b=0xA5, state_o=2, valid=1; reg_a remains 0x3C.
REQ-032 Toggle btn_load as 1,0,1,0 in single cycles -> no capture and state unchanged.
REQ-033 In READY, press again -> state_o=0, valid=0, reg_a=0x3C and reg_b=0xA5 retained.
REQ-034 Assert btn_clr on the same edge as a press event in LOAD_B -> state_o=0, reg_a=reg_b=0, load_pulse=0.
REQ-035 Assert rst for 1 cycle midway through a 3-cycle debounce count -> all outputs 0 immediately; holding the button afterwards gives a capture 6 edges after rst falls.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the operand loader.
package alu_pkg;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      READY  = 2'd2
   } loader_state_t;

   localparam int unsigned DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioning: optional 2-flop synchronizer (LOADER_SYNC_EN) plus
// counter debouncer; emits a one-cycle press on a debounced rising level.
module btn_debounce
   import alu_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic press
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
   // The toggle edge is the one on which the count would reach DEBOUNCE_CYCLES-1,
   // so the stored count never exceeds DEBOUNCE_CYCLES-2.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic             w_din;
   logic             r_level;
   logic             r_level_d;
   logic [CNT_W-1:0] r_cnt;

`ifdef LOADER_SYNC_EN
   logic r_sync1;
   logic r_sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_din = r_sync2;
`else
   assign w_din = btn_in;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_level_d <= r_level;
         if (w_din == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign press = r_level & ~r_level_d;

endmodule

// File: rtl/operand_loader.sv
// Two-operand capture FSM driven by a debounced load button.
// Define LOADER_SYNC_EN to add a 2-flop synchronizer on btn_load.
module operand_loader
   import alu_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned DATA_W          = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_load,
   input  logic              btn_clr,
   input  logic [DATA_W-1:0] sw,
   output logic [DATA_W-1:0] reg_a,
   output logic [DATA_W-1:0] reg_b,
   output logic              valid,
   output logic [1:0]        state_o,
   output logic              load_pulse
);

   localparam logic [1:0] ST_LOAD_A = LOAD_A;
   localparam logic [1:0] ST_LOAD_B = LOAD_B;
   localparam logic [1:0] ST_READY  = READY;

   logic              w_press;
   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic              r_pulse;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn_in(btn_load),
      .press (w_press)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_LOAD_A;
         r_a     <= '0;
         r_b     <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         // Clear takes priority; a press landing on the same edge is dropped.
         if (btn_clr) begin
            r_state <= ST_LOAD_A;
            r_a     <= '0;
            r_b     <= '0;
         end else begin
            case (r_state)
               ST_LOAD_A: begin
                  if (w_press) begin
                     r_a     <= sw;
                     r_state <= ST_LOAD_B;
                     r_pulse <= 1'b1;
                  end
               end
               ST_LOAD_B: begin
                  if (w_press) begin
                     r_b     <= sw;
                     r_state <= ST_READY;
                     r_pulse <= 1'b1;
                  end
               end
               ST_READY: begin
                  if (w_press) begin
                     r_state <= ST_LOAD_A;
                  end
               end
               default: r_state <= ST_LOAD_A;
            endcase
         end
      end
   end

   assign reg_a      = r_a;
   assign reg_b      = r_b;
   assign valid      = (r_state == ST_READY);
   assign state_o    = r_state;
   assign load_pulse = r_pulse;

endmodule
